// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and constants for the instruction cache and
//               its line-refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  // Refill controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int LINE_WORDS = 4;   // 32-bit words per line
  localparam int OFFS_W     = 2;   // word-offset field width
  localparam int BYTE_OFFS  = 2;   // byte-in-word bits, ignored on fetch

  typedef logic [127:0] line_t;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Tag, data and valid storage for a direct-mapped cache.
//               Combinational read port, single write port, and a flash
//               clear of every valid bit that overrides a same-cycle write.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array
  import icache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output line_t            o_rd_line,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  line_t            i_wr_line,
  input  logic             i_clr
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  line_t            r_data [SETS];

  // Valid bits: flash clear has priority so an invalidate beats a fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Direct-mapped instruction cache front end. Hits answer in
//               the same cycle; a miss stalls the CPU, issues one line
//               request, waits for the fill pulse, writes the line and
//               replays the lookup from IDLE with the current address.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_rdy_o,
  output logic [31:0]       cpu_data_o,
  input  logic              inv_i,
  output logic              ext_req_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  input  logic              ext_rsp_i,
  input  logic [LINE_W-1:0] ext_data_i,
  output logic              busy_o
);

  localparam int c_idx_w  = $clog2(SETS);
  localparam int c_idx_lo = BYTE_OFFS + OFFS_W;
  localparam int c_tag_w  = ADDR_W - c_idx_lo - c_idx_w;
  localparam int c_miss_w = c_tag_w + c_idx_w;
  localparam int c_word_w = LINE_W / LINE_WORDS;

  state_e              r_state;
  logic [c_miss_w-1:0] r_miss;      // {tag,index} of the outstanding refill

  logic [OFFS_W-1:0]   w_offs;
  logic [c_idx_w-1:0]  w_idx;
  logic [c_tag_w-1:0]  w_tag;
  logic                w_rd_valid;
  logic [c_tag_w-1:0]  w_rd_tag;
  line_t               w_rd_line;
  logic                w_hit;
  logic                w_fill;
  logic                w_unused;

  assign w_offs   = cpu_addr_i[BYTE_OFFS +: OFFS_W];
  assign w_idx    = cpu_addr_i[c_idx_lo +: c_idx_w];
  assign w_tag    = cpu_addr_i[ADDR_W-1 -: c_tag_w];
  assign w_unused = ^cpu_addr_i[BYTE_OFFS-1:0];

  // Lookups are only honoured in IDLE; REQ/WAIT stall the CPU
  assign w_hit  = cpu_req_i && (r_state == IDLE) && w_rd_valid && (w_rd_tag == w_tag);
  assign w_fill = (r_state == WAIT) && ext_rsp_i;

  icache_array #(
    .SETS  (SETS),
    .TAG_W (c_tag_w),
    .IDX_W (c_idx_w)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_we       (w_fill),
    .i_wr_idx   (r_miss[c_idx_w-1:0]),
    .i_wr_tag   (r_miss[c_miss_w-1 -: c_tag_w]),
    .i_wr_line  (line_t'(ext_data_i)),
    .i_clr      (inv_i)
  );

  // Refill sequencing: latch the missing line, pulse the request, await fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_miss  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_i && !w_hit) begin
            r_miss  <= {w_tag, w_idx};
            r_state <= REQ;
          end
        end
        REQ:     r_state <= WAIT;
        WAIT:    if (ext_rsp_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_rdy_o  = w_hit;
  assign cpu_data_o = w_rd_line[w_offs*c_word_w +: 32];
  assign ext_req_o  = (r_state == REQ);
  // Word address of the line; r_miss is only updated on a new miss so this holds
  assign ext_addr_o = {2'b00, r_miss, 2'b00};
  assign busy_o     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Scoreboard bench for icache_refill_ctrl with a behavioural
//               cache-contents model, a memory responder and a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

  logic         clk;
  logic         rst_n;
  logic         cpu_req_i;
  logic [31:0]  cpu_addr_i;
  logic         cpu_rdy_o;
  logic [31:0]  cpu_data_o;
  logic         inv_i;
  logic         ext_req_o;
  logic [31:0]  ext_addr_o;
  logic         ext_rsp_i;
  logic [127:0] ext_data_i;
  logic         busy_o;

  logic         inv_drv, inv_rsp;
  logic         rsp_r, rsp_stray;
  logic [127:0] rsp_data;
  int           rsp_delay;
  bit           inv_on_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_eaddr_q[$];

  // Model of cache contents: which line each set currently holds
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  assign inv_i      = inv_drv | inv_rsp;
  assign ext_rsp_i  = rsp_r | rsp_stray;
  assign ext_data_i = rsp_stray ? {4{32'hDEAD_BEEF}} : rsp_data;

  icache_refill_ctrl #(.SETS(16), .LINE_W(128), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req_i  (cpu_req_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_rdy_o  (cpu_rdy_o),
    .cpu_data_o (cpu_data_o),
    .inv_i      (inv_i),
    .ext_req_o  (ext_req_o),
    .ext_addr_o (ext_addr_o),
    .ext_rsp_i  (ext_rsp_i),
    .ext_data_i (ext_data_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at byte address a
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a & 32'hFFFF_FFFC) - 32'h10;
    return (w << 5) + 32'h13;
  endfunction

  function automatic logic [31:0] eaddr(input logic [31:0] a);
    return (a >> 2) & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents data or a request
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_rdy_o) begin
        if (exp_data_q.size() == 0) check("unexpected_rdy", 32'(cpu_rdy_o), 32'd0);
        else                        check("rd_data", cpu_data_o, exp_data_q.pop_front());
      end
      if (ext_req_o) begin
        check("busy_at_req", 32'(busy_o), 32'd1);
        if (exp_eaddr_q.size() == 0) check("unexpected_req", 32'(ext_req_o), 32'd0);
        else                         check("ext_addr", ext_addr_o, exp_eaddr_q.pop_front());
      end
    end
  end

  // Memory responder: answers each request after rsp_delay cycles
  initial begin
    logic [31:0] wa;
    bit aborted;
    rsp_r = 1'b0; inv_rsp = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      if (ext_req_o && rst_n) begin
        wa = ext_addr_o;
        aborted = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
          @(posedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        #1;
        if (!rst_n) aborted = 1'b1;
        if (!aborted) begin
          for (int k = 0; k < 4; k++) rsp_data[32*k +: 32] = mem_word((wa << 2) + 32'(4*k));
          rsp_r = 1'b1;
          inv_rsp = inv_on_rsp;
          inv_on_rsp = 1'b0;
          @(posedge clk); #1;
          rsp_r = 1'b0;
          inv_rsp = 1'b0;
        end
      end
    end
  end

  // mode 0: plain fetch; 1: invalidate together with the fill (if a miss);
  // 2: invalidate together with the hit (if a hit)
  task automatic fetch(input logic [31:0] a, input int mode);
    int idx, exp_lat, lat;
    logic [23:0] tg;
    bit hit, inv_now;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    inv_now = (mode == 2) && hit;
    if (hit) begin
      exp_lat = 0;
    end else begin
      exp_eaddr_q.push_back(eaddr(a));
      exp_lat = 2 + rsp_delay;
      if (mode == 1) begin
        exp_eaddr_q.push_back(eaddr(a));
        exp_lat = 4 + 2 * rsp_delay;
        model_clear();
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    inv_on_rsp = !hit && (mode == 1);
    exp_data_q.push_back(mem_word(a));
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_addr_i = a; inv_drv = inv_now;
    lat = 0;
    @(negedge clk);
    while (!cpu_rdy_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("fetch_latency", 32'(lat), 32'(exp_lat));
    if (inv_now) model_clear();
  endtask

  task automatic do_inv();
    @(posedge clk); #1;
    cpu_req_i = 1'b0; inv_drv = 1'b1;
    @(posedge clk); #1;
    inv_drv = 1'b0;
    model_clear();
  endtask

  task automatic stray_rsp();
    @(posedge clk); #1;
    cpu_req_i = 1'b0; inv_drv = 1'b0; rsp_stray = 1'b1;
    @(posedge clk); #1;
    rsp_stray = 1'b0;
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    int n;
    do_inv();
    rsp_delay = 20;
    exp_eaddr_q.push_back(eaddr(a));
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_addr_i = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ext_req_o && n < 50);
    check("rst_req_seen", 32'(ext_req_o), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("busy_in_wait", 32'(busy_o), 32'd1);
    rst_n = 1'b0; cpu_req_i = 1'b0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rdy", 32'(cpu_rdy_o), 32'd0);
    check("rst_ext_req", 32'(ext_req_o), 32'd0);
    check("rst_ext_addr", ext_addr_o, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0;
    inv_drv = 1'b0; rsp_stray = 1'b0; inv_on_rsp = 1'b0; rsp_delay = 4;
    model_clear();
    #3;
    check("reset_rdy", 32'(cpu_rdy_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_ext_req", 32'(ext_req_o), 32'd0);
    check("reset_ext_addr", ext_addr_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold miss with an 80-cycle memory, then same-line hits
    rsp_delay = 80;
    fetch(32'h0000_0010, 0);
    fetch(32'h0000_0014, 0);
    fetch(32'h0000_0018, 0);
    fetch(32'h0000_001C, 0);

    // Conflict eviction on set 1
    rsp_delay = 5;
    fetch(32'h0000_0110, 0);
    fetch(32'h0000_0010, 0);

    // Invalidate, then refetch
    do_inv();
    fetch(32'h0000_0010, 0);

    // Invalidate during the fill write, then invalidate alongside a hit
    do_inv();
    fetch(32'h0000_0010, 1);
    fetch(32'h0000_0014, 2);
    fetch(32'h0000_0018, 0);

    // Stray responses in IDLE must not touch valid bits or data
    fetch(32'h0000_0020, 0);
    do_inv();
    stray_rsp();
    fetch(32'h0000_0024, 0);
    stray_rsp();
    fetch(32'h0000_0028, 0);

    // Asynchronous reset in WAIT drops the refill and clears the cache
    fetch(32'h0000_0030, 0);
    reset_mid_refill(32'h0000_0140);
    rsp_delay = 3;
    fetch(32'h0000_0030, 0);

    // Randomised traffic over a few sets and tags
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'h0000_0000;
        1:       a = 32'h0000_0100;
        default: a = 32'hABCD_E000;
      endcase
      a = a | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      rsp_delay = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if (r == 0)      do_inv();
      else if (r == 1) fetch(a, 1);
      else if (r == 2) fetch(a, 2);
      else             fetch(a, 0);
    end

    @(posedge clk); #1;
    cpu_req_i = 1'b0; inv_drv = 1'b0;
    repeat (5) @(posedge clk);
    check("data_q_drained", 32'(exp_data_q.size()), 32'd0);
    check("req_q_drained", 32'(exp_eaddr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped instruction cache with a line-refill initiator, between the CPU fetch port and the 128-bit line-fill memory controller.
- Hits return an instruction word combinationally in the same cycle.
- A miss stalls the CPU, issues one line request to the memory side, and waits for the response pulse. It then writes the whole line and replays the lookup.

Parameters:
- SETS, 16, number of cache lines (power of two, >= 2).
- LINE_W, 128, line width in bits (4 x 32-bit words; fixed by the memory interface).
- ADDR_W, 32, CPU byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_i  in  1  fetch request valid.
- cpu_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- cpu_rdy_o  out  1  cpu_data_o valid this cycle (hit).
- cpu_data_o  out  32  instruction word.
- inv_i  in  1  invalidate all lines (fence.i).
- ext_req_o  out  1  line request, single-cycle pulse.
- ext_addr_o  out  32  line-aligned word address (cpu_addr[31:2] with [1:0]=0, zero-extended).
- ext_rsp_i  in  1  line data valid, single-cycle pulse.
- ext_data_i  in  128  line data; word k at bits [32k+31:32k].
- busy_o  out  1  refill in progress.

Behaviour:
- Reset is asynchronous and active-low. Reset values: all valid bits 0, state IDLE, ext_req_o=0, ext_addr_o=0, busy_o=0, cpu_rdy_o=0. cpu_data_o is don't-care while cpu_rdy_o=0. Tag and data arrays have no reset.
- Address split: offset=addr[3:2], index=addr[4+IDX-1:4] with IDX=$clog2(SETS), tag=addr[31:4+IDX].
- Hit condition: cpu_req_i & state==IDLE & valid[index] & tag_arr[index]==tag. On a hit, cpu_rdy_o=1 and cpu_data_o=word[offset] in the same cycle.
- IDLE: a miss (cpu_req_i & ~hit) latches {tag,index} into miss_addr_ff and moves to REQ. cpu_rdy_o=0.
- REQ (1 cycle): ext_req_o=1, ext_addr_o={miss tag,index,2'b00} word address; then go to WAIT. ext_addr_o holds its value until the next request.
- WAIT: stay until ext_rsp_i=1. In that cycle, capture ext_data_i into data_arr[miss index], the tag into tag_arr, set valid, and go to IDLE.
- No CPU hit is served in REQ/WAIT. busy_o=1 in REQ and WAIT.
- Miss-to-data latency: miss cycle t, ext_req_o at t+1, rsp at t+1+D, hit at t+2+D (replayed lookup in IDLE).
- CPU redirect during refill: the refill completes for the latched address. The lookup after IDLE uses the current cpu_addr_i and may miss again.
- ext_rsp_i outside WAIT is ignored (no state or array change).
- inv_i: clears all valid bits at the next edge, in any state. It does not abort the FSM.
- inv_i in the same cycle as a WAIT fill write: inv wins, so the filled line's valid stays 0 and the next lookup misses.
- inv_i in IDLE together with a hit: the hit is still served this cycle.
- Reset mid-refill: FSM returns to IDLE and the outstanding response is dropped. The memory side is reset by the same rst_n.
- Only one outstanding request at a time. ext_req_o is never asserted in WAIT.

Decomposition:
- Package icache_pkg holds:
  - state enum (IDLE, REQ, WAIT), 2 bits;
  - localparams LINE_WORDS=4, OFFS_W=2, BYTE_OFFS=2;
  - typedef line_t = logic [127:0].
- One sub-module, icache_array: tag, data and valid storage with a combinational read port, one write port, and a flash-clear of valid.

Test Plan:
- Cold miss: reset, cpu_req=1, addr=0x0000_0010. Required: cpu_rdy=0; ext_req pulse one cycle later with ext_addr=0x4. The model responds after 80 cycles with data words {0x13,0x93,0x113,0x193}. The following cycle cpu_rdy=1, data=0x13.
- Same-line hits: after the fill, addrs 0x14, 0x18, 0x1C return 0x93, 0x113, 0x193 with cpu_rdy=1 each cycle and no ext_req.
- Conflict eviction (SETS=16): fill 0x010, then fetch 0x110 (same index 1, different tag). Required: ext_req with ext_addr=0x44; after the fill, 0x010 misses again.
- Invalidate: with line 0x010 valid, pulse inv_i for one cycle. Required: the next fetch of 0x010 misses and ext_req is issued.
- Inv during fill: assert inv_i in the same cycle as ext_rsp_i. Required: FSM returns to IDLE, the replayed lookup misses, and a second ext_req is issued.
- Stray response and reset: an ext_rsp_i pulse in IDLE leaves valid unchanged and gives no cpu_rdy. Asserting rst_n=0 in WAIT gives state IDLE and busy_o=0 immediately (async), with all valid bits cleared.
